load_store_queue: RTL

LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

---
 rtl/types_pkg.sv | 35 +++
 rtl/lsq_byte_match.sv | 55 +++++
 rtl/load_store_queue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : types_pkg
// Purpose  : Shared load/store queue entry layout and memory access sizes.
// Revision : 1.0
// ============================================================================
package types_pkg;

   // Entry field widths; size these for the widest queue instance in the design.
   localparam int c_tag_w = 5;
   localparam int c_xlen  = 32;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2,
      MEM_RSVD = 2'd3
   } mem_size_t;

   typedef struct packed {
      logic               valid;
      logic               resolved;
      logic               is_store;
      logic [c_tag_w-1:0] tag;
      logic [c_xlen-1:0]  addr;
      logic [c_xlen-1:0]  data;
      mem_size_t          size;
   } lsq_entry_t;

   function automatic logic [3:0] size_bytes(input mem_size_t s);
      return 4'd1 << s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsq_byte_match.sv
`default_nettype none
// ============================================================================
// Module   : lsq_byte_match
// Purpose  : Byte-range overlap/cover test of one store against a load query,
//            plus the store bytes realigned to the load address.
// Revision : 1.0
// ============================================================================
module lsq_byte_match
   import types_pkg::*;
#(
   parameter int XLEN = c_xlen
) (
   input  logic [XLEN-1:0] st_addr,
   input  logic [XLEN-1:0] st_data,
   input  mem_size_t       st_size,
   input  logic [XLEN-1:0] ld_addr,
   input  mem_size_t       ld_size,
   output logic            overlap,
   output logic            covers,
   output logic [XLEN-1:0] slice
);

   // Extra headroom bits so a range ending past the top of memory does not wrap.
   localparam int c_ext_w = XLEN + 4;

   logic [c_ext_w-1:0] w_st_lo;
   logic [c_ext_w-1:0] w_st_hi;
   logic [c_ext_w-1:0] w_ld_lo;
   logic [c_ext_w-1:0] w_ld_hi;
   logic [XLEN-1:0]    w_byte_off;
   logic [XLEN-1:0]    w_shifted;
   logic [XLEN-1:0]    w_mask;

   assign w_st_lo = c_ext_w'(st_addr);
   assign w_ld_lo = c_ext_w'(ld_addr);
   assign w_st_hi = w_st_lo + c_ext_w'(size_bytes(st_size)) - c_ext_w'(1);
   assign w_ld_hi = w_ld_lo + c_ext_w'(size_bytes(ld_size)) - c_ext_w'(1);

   assign overlap = (w_st_lo <= w_ld_hi) && (w_ld_lo <= w_st_hi);
   assign covers  = (w_st_lo <= w_ld_lo) && (w_ld_hi <= w_st_hi);

   assign w_byte_off = ld_addr - st_addr;
   assign w_shifted  = st_data >> {w_byte_off, 3'b000};

   always_comb begin
      w_mask = '0;
      for (int b = 0; b < XLEN / 8; b++) begin
         w_mask[8*b +: 8] = (4'(b) < size_bytes(ld_size)) ? 8'hFF : 8'h00;
      end
   end

   assign slice = w_shifted & w_mask;

endmodule
`default_nettype wire

// File: rtl/load_store_queue.sv
`default_nettype none
// ============================================================================
// Module   : load_store_queue
// Purpose  : In-order load/store queue with store-to-load forwarding and
//            registered store commit on retire.
// Revision : 1.0
// ============================================================================
module load_store_queue
   import types_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int TAG_W = c_tag_w,
   parameter int XLEN  = c_xlen
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      dispatch_valid,
   input  logic [TAG_W-1:0]          dispatch_tag,
   input  logic                      dispatch_is_store,
   output logic                      dispatch_ready,
   input  logic                      exec_valid,
   input  logic [TAG_W-1:0]          exec_tag,
   input  logic [XLEN-1:0]           exec_base,
   input  logic [XLEN-1:0]           exec_imm,
   input  logic [XLEN-1:0]           exec_data,
   input  logic [1:0]                exec_size,
   input  logic                      ld_valid,
   input  logic [TAG_W-1:0]          ld_tag,
   input  logic [XLEN-1:0]           ld_addr,
   input  logic [1:0]                ld_size,
   output logic                      fwd_hit,
   output logic [XLEN-1:0]           fwd_data,
   output logic                      fwd_stall,
   input  logic                      retire_valid,
   input  logic [TAG_W-1:0]          retire_tag,
   output logic                      commit_valid,
   output logic [XLEN-1:0]           commit_addr,
   output logic [XLEN-1:0]           commit_data,
   output logic [1:0]                commit_size,
   input  logic                      flush,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;

   lsq_entry_t          r_entries [DEPTH];
   logic [c_ptr_w-1:0]  r_head;
   logic [c_ptr_w-1:0]  r_tail;
   logic [c_cnt_w-1:0]  r_count;
   logic                r_commit_valid;
   logic [XLEN-1:0]     r_commit_addr;
   logic [XLEN-1:0]     r_commit_data;
   mem_size_t           r_commit_size;

   logic                w_full;
   logic                w_disp;
   logic                w_deq;
   logic                w_exec_hit;
   logic [c_ptr_w-1:0]  w_exec_idx;
   logic [XLEN-1:0]     w_exec_addr;
   logic [DEPTH-1:0]    w_overlap;
   logic [DEPTH-1:0]    w_covers;
   logic [XLEN-1:0]     w_slice [DEPTH];
   logic [c_ptr_w-1:0]  w_scan_idx;
   logic                w_ld_found;
   logic                w_older_unres;
   logic                w_have_store;
   logic [c_ptr_w-1:0]  w_young;

   assign w_full         = (r_count == c_cnt_w'(DEPTH));
   assign full           = w_full;
   assign empty          = (r_count == '0);
   assign dispatch_ready = !w_full;
   assign count          = r_count;
   assign commit_valid   = r_commit_valid;
   assign commit_addr    = r_commit_addr;
   assign commit_data    = r_commit_data;
   assign commit_size    = r_commit_size;

   assign w_disp      = dispatch_valid && !w_full;
   assign w_deq       = retire_valid && r_entries[r_head].valid && r_entries[r_head].resolved
                        && (r_entries[r_head].tag == c_tag_w'(retire_tag));
   assign w_exec_addr = exec_base + exec_imm;

   always_comb begin
      w_exec_hit = 1'b0;
      w_exec_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!w_exec_hit && r_entries[i].valid && !r_entries[i].resolved
             && (r_entries[i].tag == c_tag_w'(exec_tag))) begin
            w_exec_hit = 1'b1;
            w_exec_idx = c_ptr_w'(i);
         end
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      lsq_byte_match #(.XLEN(XLEN)) u_match (
         .st_addr (XLEN'(r_entries[gi].addr)),
         .st_data (XLEN'(r_entries[gi].data)),
         .st_size (r_entries[gi].size),
         .ld_addr (ld_addr),
         .ld_size (mem_size_t'(ld_size)),
         .overlap (w_overlap[gi]),
         .covers  (w_covers[gi]),
         .slice   (w_slice[gi])
      );
   end

   // Walk oldest-first; the last overlapping resolved store seen before the load is the youngest.
   always_comb begin
      w_scan_idx    = '0;
      w_ld_found    = 1'b0;
      w_older_unres = 1'b0;
      w_have_store  = 1'b0;
      w_young       = '0;
      for (int p = 0; p < DEPTH; p++) begin
         w_scan_idx = r_head + c_ptr_w'(p);
         if (!w_ld_found && (c_cnt_w'(p) < r_count)) begin
            if (r_entries[w_scan_idx].tag == c_tag_w'(ld_tag)) begin
               w_ld_found = 1'b1;
            end else if (r_entries[w_scan_idx].is_store) begin
               if (!r_entries[w_scan_idx].resolved) begin
                  w_older_unres = 1'b1;
               end else if (w_overlap[w_scan_idx]) begin
                  w_have_store = 1'b1;
                  w_young      = w_scan_idx;
               end
            end
         end
      end
   end

   always_comb begin
      fwd_hit   = 1'b0;
      fwd_stall = 1'b0;
      fwd_data  = '0;
      if (ld_valid && w_ld_found) begin
         if (w_older_unres) begin
            fwd_stall = 1'b1;
         end else if (w_have_store) begin
            if (w_covers[w_young]) begin
               fwd_hit  = 1'b1;
               fwd_data = w_slice[w_young];
            end else begin
               fwd_stall = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_commit_valid <= 1'b0;
         r_commit_addr  <= '0;
         r_commit_data  <= '0;
         r_commit_size  <= MEM_BYTE;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_commit_valid <= 1'b0;
      end else begin
         r_commit_valid <= 1'b0;
         if (w_deq) begin
            r_entries[r_head] <= '0;
            r_head            <= r_head + c_ptr_w'(1);
            if (r_entries[r_head].is_store) begin
               r_commit_valid <= 1'b1;
               r_commit_addr  <= XLEN'(r_entries[r_head].addr);
               r_commit_data  <= XLEN'(r_entries[r_head].data);
               r_commit_size  <= r_entries[r_head].size;
            end
         end
         if (w_disp) begin
            r_entries[r_tail] <= '{valid: 1'b1, resolved: 1'b0, is_store: dispatch_is_store,
                                   tag: c_tag_w'(dispatch_tag), addr: '0, data: '0,
                                   size: MEM_BYTE};
            r_tail            <= r_tail + c_ptr_w'(1);
         end
         if (exec_valid && w_exec_hit) begin
            r_entries[w_exec_idx].resolved <= 1'b1;
            r_entries[w_exec_idx].addr     <= c_xlen'(w_exec_addr);
            r_entries[w_exec_idx].data     <= c_xlen'(exec_data);
            r_entries[w_exec_idx].size     <= mem_size_t'(exec_size);
         end
         r_count <= r_count + c_cnt_w'(w_disp) - c_cnt_w'(w_deq);
      end
   end

endmodule
`default_nettype wire
